fir_avmm_csr: RTL and testbench

- Avalon-MM slave (responder) on the fabric side of the Nios mm_bridge master port.
- Exposes FIR control/status registers and a shadow coefficient bank to software.
- A commit copies the shadow bank into the active bank that the FIR datapath reads.
- Fixed 2-cycle pipelined read latency; waitrequest is used only to stall coefficient writes during a copy.

---
 rtl/fir_avmm_csr_if.sv | 39 +++
 rtl/fir_avmm_csr.sv | 190 +++++++++++++++++++
 tb/tb_fir_avmm_csr.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_avmm_csr_if.sv
// Avalon-MM bus bundle between the mm_bridge master and the FIR CSR responder.
interface fir_avmm_csr_if;
  logic [9:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_burstcount;
  logic        avs_debugaccess;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    output avs_burstcount,
    output avs_debugaccess,
    input  avs_waitrequest,
    input  avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    input  avs_burstcount,
    input  avs_debugaccess,
    output avs_waitrequest,
    output avs_readdata,
    output avs_readdatavalid
  );
endinterface

// File: rtl/fir_avmm_csr.sv
// FIR control/status registers with a shadow coefficient bank that software fills and
// commits into the active bank read by the datapath. Fixed 2-cycle read latency.
module fir_avmm_csr #(
  parameter int unsigned NUM_TAPS = 32,
  parameter int unsigned COEF_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  fir_avmm_csr_if.slave     avs,
  output logic              fir_enable,
  input  logic [5:0]        coef_rd_idx,
  output logic [COEF_W-1:0] coef_rd_data,
  output logic              coef_update_done
);

  typedef enum logic [0:0] {StIdle, StCopy} state_e;

  localparam logic [6:0] NumTaps7 = 7'(NUM_TAPS);
  localparam logic [5:0] LastIdx  = 6'(NUM_TAPS - 1);
  localparam logic [7:0] NumTaps8 = 8'(NUM_TAPS);

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              enable_q, enable_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [15:0]       commit_cnt_q, commit_cnt_d;
  logic [COEF_W-1:0] shadow_q [NUM_TAPS];
  logic [COEF_W-1:0] shadow_d [NUM_TAPS];
  logic [COEF_W-1:0] active_q [NUM_TAPS];
  logic [COEF_W-1:0] active_d [NUM_TAPS];
  logic              rd1_valid_q, rd1_valid_d;
  logic [31:0]       rd1_data_q, rd1_data_d;
  logic              rd2_valid_q;
  logic [31:0]       rd2_data_q;
  logic [COEF_W-1:0] coef_rd_data_q, coef_rd_data_d;

  logic [7:0]        word_idx;
  logic [5:0]        coef_k;
  logic              is_ctrl, is_status, is_scratch, is_coef_region, coef_hit;
  logic              copy_busy, wait_req, wr_en, rd_en, commit_req;
  logic [31:0]       be_mask;
  logic [31:0]       rd_mux;
  logic [COEF_W-1:0] shadow_sel;
  logic              done;
  logic              unused_sigs;

  // Address decode
  assign word_idx       = avs.avs_address[9:2];
  assign coef_k         = avs.avs_address[7:2];
  assign is_ctrl        = (word_idx == 8'd0);
  assign is_status      = (word_idx == 8'd1);
  assign is_scratch     = (word_idx == 8'd2);
  assign is_coef_region = (avs.avs_address[9:8] == 2'b01);
  assign coef_hit       = is_coef_region && ({1'b0, coef_k} < NumTaps7);

  assign copy_busy  = (state_q == StCopy);
  // Only coefficient writes stall, so the active bank never races a shadow update.
  assign wait_req   = avs.avs_write & copy_busy & is_coef_region;
  assign wr_en      = avs.avs_write & ~wait_req;
  assign rd_en      = avs.avs_read & ~avs.avs_write;
  assign commit_req = wr_en & is_ctrl & avs.avs_byteenable[0] & avs.avs_writedata[1];

  assign unused_sigs = ^{avs.avs_burstcount, avs.avs_debugaccess, avs.avs_address[1:0]};

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) begin
      be_mask[8*b +: 8] = {8{avs.avs_byteenable[b]}};
    end
  end

  always_comb begin
    shadow_sel = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (coef_k == 6'(k)) shadow_sel = shadow_q[k];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (is_ctrl) begin
      rd_mux = {31'd0, enable_q};
    end else if (is_status) begin
      rd_mux = {commit_cnt_q, NumTaps8, 7'd0, copy_busy};
    end else if (is_scratch) begin
      rd_mux = scratch_q;
    end else if (coef_hit) begin
      rd_mux = 32'(shadow_sel);
    end
  end

  // Register writes
  always_comb begin
    enable_d  = enable_q;
    scratch_d = scratch_q;
    shadow_d  = shadow_q;
    if (wr_en) begin
      if (is_ctrl && avs.avs_byteenable[0]) enable_d = avs.avs_writedata[0];
      if (is_scratch) scratch_d = (scratch_q & ~be_mask) | (avs.avs_writedata & be_mask);
      if (coef_hit) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          if (coef_k == 6'(k)) begin
            shadow_d[k] = COEF_W'((32'(shadow_q[k]) & ~be_mask)
                                  | (avs.avs_writedata & be_mask));
          end
        end
      end
    end
  end

  // Commit FSM: one tap copied per cycle
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    commit_cnt_d = commit_cnt_q;
    active_d     = active_q;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit_req) begin
          state_d      = StCopy;
          idx_d        = '0;
          commit_cnt_d = commit_cnt_q + 16'd1;
        end
      end
      StCopy: begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          if (idx_q == 6'(k)) active_d[k] = shadow_q[k];
        end
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          done    = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd1_valid_d = rd_en;
    rd1_data_d  = rd_en ? rd_mux : '0;
  end

  always_comb begin
    coef_rd_data_d = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (coef_rd_idx == 6'(k)) coef_rd_data_d = active_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      enable_q       <= 1'b0;
      scratch_q      <= '0;
      commit_cnt_q   <= '0;
      shadow_q       <= '{default: '0};
      active_q       <= '{default: '0};
      rd1_valid_q    <= 1'b0;
      rd1_data_q     <= '0;
      rd2_valid_q    <= 1'b0;
      rd2_data_q     <= '0;
      coef_rd_data_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      enable_q       <= enable_d;
      scratch_q      <= scratch_d;
      commit_cnt_q   <= commit_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      rd1_valid_q    <= rd1_valid_d;
      rd1_data_q     <= rd1_data_d;
      rd2_valid_q    <= rd1_valid_q;
      rd2_data_q     <= rd1_data_q;
      coef_rd_data_q <= coef_rd_data_d;
    end
  end

  assign avs.avs_waitrequest   = wait_req;
  assign avs.avs_readdata      = rd2_data_q;
  assign avs.avs_readdatavalid = rd2_valid_q;
  assign fir_enable            = enable_q;
  assign coef_rd_data          = coef_rd_data_q;
  assign coef_update_done      = done;

endmodule

// File: tb/tb_fir_avmm_csr.sv
// Directed bench for fir_avmm_csr: register map, read latency, commit copy, stalls, reset.
module tb_fir_avmm_csr;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        fir_enable;
  logic [5:0]  coef_rd_idx;
  logic [15:0] coef_rd_data;
  logic        coef_update_done;
  int          n_vec = 0;
  int          n_err = 0;

  fir_avmm_csr_if avs ();

  fir_avmm_csr #(.NUM_TAPS(32), .COEF_W(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs              (avs),
    .fir_enable       (fir_enable),
    .coef_rd_idx      (coef_rd_idx),
    .coef_rd_data     (coef_rd_data),
    .coef_update_done (coef_update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted at the next edge; checks valid stays low one cycle, then data in cycle N+2.
  task automatic do_read(input logic [9:0] addr, input logic [31:0] exp, input string tag);
    avs.avs_address = addr;
    avs.avs_read    = 1'b1;
    tick();
    avs.avs_read = 1'b0;
    check({tag, "_lat1"}, 32'(avs.avs_readdatavalid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(avs.avs_readdatavalid), 32'd1);
    check(tag, avs.avs_readdata, exp);
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int stalls);
    avs.avs_address    = addr;
    avs.avs_writedata  = data;
    avs.avs_byteenable = be;
    avs.avs_write      = 1'b1;
    #1;
    stalls = 0;
    while (avs.avs_waitrequest && stalls < 100) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    @(posedge clk);
    #1;
    avs.avs_write = 1'b0;
  endtask

  initial begin
    int st;
    int done_cnt;
    int done_at;

    reset_n             = 1'b1;
    avs.avs_address     = '0;
    avs.avs_read        = 1'b0;
    avs.avs_write       = 1'b0;
    avs.avs_writedata   = '0;
    avs.avs_byteenable  = '0;
    avs.avs_burstcount  = 1'b1;
    avs.avs_debugaccess = 1'b0;
    coef_rd_idx         = '0;
    #1 reset_n = 1'b0;
    tick();
    tick();

    // 1. reset state and STATUS read latency
    check("rst_rdv", 32'(avs.avs_readdatavalid), 32'd0);
    check("rst_rdata", avs.avs_readdata, 32'd0);
    check("rst_wait", 32'(avs.avs_waitrequest), 32'd0);
    check("rst_en", 32'(fir_enable), 32'd0);
    check("rst_coef", 32'(coef_rd_data), 32'd0);
    check("rst_done", 32'(coef_update_done), 32'd0);
    reset_n = 1'b1;
    tick();
    avs.avs_address = 10'h004;
    avs.avs_read    = 1'b1;
    #1 check("rd_wait", 32'(avs.avs_waitrequest), 32'd0);
    avs.avs_read = 1'b0;
    do_read(10'h004, 32'h0000_2000, "status0");

    // 2. SCRATCH byte enables, back-to-back reads
    do_write(10'h008, 32'hA5A5_A5A5, 4'hF, st);
    do_write(10'h008, 32'h1234_5678, 4'h5, st);
    do_read(10'h008, 32'hA534_A578, "scratch_be");
    avs.avs_read    = 1'b1;
    avs.avs_address = 10'h000;
    tick();
    avs.avs_address = 10'h004;
    tick();
    avs.avs_address = 10'h008;
    check("b2b0_v", 32'(avs.avs_readdatavalid), 32'd1);
    check("b2b0_d", avs.avs_readdata, 32'd0);
    tick();
    avs.avs_read = 1'b0;
    check("b2b1_v", 32'(avs.avs_readdatavalid), 32'd1);
    check("b2b1_d", avs.avs_readdata, 32'h0000_2000);
    tick();
    check("b2b2_v", 32'(avs.avs_readdatavalid), 32'd1);
    check("b2b2_d", avs.avs_readdata, 32'hA534_A578);
    tick();
    check("b2b_end", 32'(avs.avs_readdatavalid), 32'd0);

    // 3. load coefficients and commit
    for (int k = 0; k < 32; k++) begin
      do_write(10'h100 + 10'(4 * k), 32'(k + 1), 4'hF, st);
    end
    do_write(10'h000, 32'h3, 4'hF, st);
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 40; i++) begin
      if (coef_update_done) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 0) begin
        avs.avs_address = 10'h004;
        avs.avs_read    = 1'b1;
      end
      if (i == 1) avs.avs_read = 1'b0;
      if (i == 2) check("status_busy", avs.avs_readdata, 32'h0001_2001);
      tick();
    end
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("done_at", 32'(done_at), 32'd31);
    check("enable", 32'(fir_enable), 32'd1);
    do_read(10'h004, 32'h0001_2000, "status_c1");
    coef_rd_idx = 6'd5;
    tick();
    check("coef5", 32'(coef_rd_data), 32'd6);
    coef_rd_idx = 6'd31;
    tick();
    check("coef31", 32'(coef_rd_data), 32'd32);
    coef_rd_idx = 6'd40;
    tick();
    check("coef40", 32'(coef_rd_data), 32'd0);

    // 4. stall during copy, second commit ignored
    do_write(10'h000, 32'h3, 4'hF, st);
    do_write(10'h000, 32'h3, 4'hF, st);
    check("ctrl_nostall", 32'(st), 32'd0);
    do_write(10'h104, 32'h0000_0077, 4'hF, st);
    check("coef_stall", 32'(st), 32'd31);
    do_read(10'h004, 32'h0002_2000, "status_c2");
    do_read(10'h104, 32'h0000_0077, "shadow1");
    coef_rd_idx = 6'd1;
    tick();
    check("active1", 32'(coef_rd_data), 32'd2);
    do_write(10'h108, 32'hFFFF_FFFF, 4'hF, st);
    do_read(10'h108, 32'h0000_FFFF, "coef_upper");
    do_write(10'h108, 32'h0000_1234, 4'h2, st);
    do_read(10'h108, 32'h0000_12FF, "coef_be");

    // 5. boundaries
    do_write(10'h180, 32'h0000_FFFF, 4'hF, st);
    do_read(10'h180, 32'd0, "coef32");
    do_read(10'h1FC, 32'd0, "coef63");
    do_read(10'h00C, 32'd0, "unmapped");
    do_write(10'h004, 32'hFFFF_FFFF, 4'hF, st);
    do_read(10'h004, 32'h0002_2000, "status_ro");
    do_write(10'h000, 32'h0, 4'hE, st);
    check("ctrl_be", 32'(fir_enable), 32'd1);
    do_read(10'h000, 32'h1, "ctrl_rd");
    avs.avs_address    = 10'h008;
    avs.avs_writedata  = 32'hDEAD_BEEF;
    avs.avs_byteenable = 4'hF;
    avs.avs_read       = 1'b1;
    avs.avs_write      = 1'b1;
    tick();
    avs.avs_read  = 1'b0;
    avs.avs_write = 1'b0;
    check("rw_v1", 32'(avs.avs_readdatavalid), 32'd0);
    tick();
    check("rw_v2", 32'(avs.avs_readdatavalid), 32'd0);
    tick();
    check("rw_v3", 32'(avs.avs_readdatavalid), 32'd0);
    do_read(10'h008, 32'hDEAD_BEEF, "rw_write");

    // 6. reset in the middle of a copy with a read in flight
    coef_rd_idx = 6'd5;
    do_write(10'h000, 32'h3, 4'hF, st);
    repeat (5) tick();
    check("pre_rst_coef", 32'(coef_rd_data), 32'd6);
    avs.avs_address = 10'h008;
    avs.avs_read    = 1'b1;
    tick();
    avs.avs_read = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_en", 32'(fir_enable), 32'd0);
    check("arst_coef", 32'(coef_rd_data), 32'd0);
    check("arst_done", 32'(coef_update_done), 32'd0);
    check("arst_rdata", avs.avs_readdata, 32'd0);
    tick();
    check("arst_rdv", 32'(avs.avs_readdatavalid), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rdv", 32'(avs.avs_readdatavalid), 32'd0);
    do_read(10'h004, 32'h0000_2000, "status_post");
    for (int k = 0; k < 32; k++) begin
      do_read(10'h100 + 10'(4 * k), 32'd0, "shadow_clr");
      coef_rd_idx = 6'(k);
      tick();
      check("active_clr", 32'(coef_rd_data), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
